tcam_ctrl: RTL and testbench
============================

TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge active.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  controller can accept.
REQ-004 SHALL have ports: cmd_op  in  2  00 write, 01 search, 10 clear, 11 reserved.
REQ-005 SHALL have ports: cmd_data  in  16  key/entry value; cmd_mask  in  16  don't-care bits (1 = ignore).
REQ-006 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-007 SHALL have ports: rsp_hit  out  1; rsp_index  out  4  lowest matching entry; rsp_multi  out  1  more than one entry matched; rsp_err  out  1.
REQ-008 SHALL have ports: entry_count  out  5  entries written since last clear, 0..16.
REQ-009 SHALL have ports: tcam_reset  out  1  active-high TCAM clear; tcam_write_enable  out  1; tcam_data  out  16; tcam_mask  out  16.
REQ-010 SHALL have ports: tcam_hits  in  16  per-entry match vector; tcam_write_success  in  1  last write stored.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, WCHK, SEARCH, SCAP, CLEAR, RESP.
REQ-012 SHALL assert cmd_ready only in IDLE; a command is accepted on a clk edge with cmd_valid=1 and cmd_ready=1.
REQ-013 SHALL register cmd_op, cmd_data and cmd_mask on acceptance and hold tcam_data/tcam_mask stable until return to IDLE.
REQ-014 Write, entry_count<16: IDLE->WRITE; WRITE asserts tcam_write_enable for exactly one cycle; WCHK samples tcam_write_success; WCHK->RESP.
REQ-015 Write success SHALL increment entry_count by 1, rsp_err=0, rsp_hit=0, and set rsp_index to the pre-increment count (slot written).
REQ-016 Write with tcam_write_success=0 in WCHK SHALL give rsp_err=1 and leave entry_count unchanged.
REQ-017 Write with entry_count=16 SHALL go IDLE->RESP directly, never assert tcam_write_enable, and give rsp_err=1, rsp_index=0.
REQ-018 Search: IDLE->SEARCH (tcam_write_enable=0, key driven one cycle) ->SCAP (tcam_hits sampled) ->RESP.
REQ-019 Search result: rsp_hit = OR of sampled hits; rsp_index = lowest set bit index (0 when no hit); rsp_multi = 1 iff two or more bits set; rsp_err=0.
REQ-020 Clear: IDLE->CLEAR asserts tcam_reset for exactly one cycle, sets entry_count=0, ->RESP with rsp_err=0, rsp_hit=0.
REQ-021 Reserved op 11: IDLE->RESP, no TCAM activity, rsp_err=1.
REQ-022 In RESP rsp_valid=1 and all rsp_* stable; RESP->IDLE on a clk edge with rsp_ready=1; otherwise hold indefinitely.
REQ-023 Latency from acceptance edge to first rsp_valid cycle: write 3 cycles, search 3, clear 2, full-write or reserved 1.
REQ-024 tcam_write_enable and tcam_reset SHALL never be 1 in the same cycle; outside WRITE/CLEAR both are 0.
REQ-025 entry_count SHALL saturate at 16 and never wrap; it changes only in WCHK (success) or CLEAR.
REQ-026 Back-to-back commands SHALL be accepted no earlier than the cycle after the RESP handshake (one IDLE cycle minimum).

Reset
REQ-027 While reset=0 SHALL asynchronously force state IDLE, entry_count=0, cmd_ready=0, rsp_valid=0, rsp_hit=0, rsp_index=0, rsp_multi=0, rsp_err=0, tcam_write_enable=0, tcam_data=0, tcam_mask=0, tcam_reset=1.
REQ-028 On first clk edge after reset deasserts SHALL drop tcam_reset to 0, enter IDLE with cmd_ready=1.
REQ-029 Reset asserted mid-command SHALL abort it with no response; the pending command is lost and entry_count=0.

Verification
REQ-030 Write data=0x0060 mask=0x000F then search key=0x006A -> rsp_hit=1, rsp_index=0, rsp_multi=0, entry_count=1.
REQ-031 Write 0x007E/0x0052 and 0x00E9/0x0000, search 0x00E9 -> rsp_hit=1, rsp_index=1 only if entry 0 misses; search 0x1234 -> rsp_hit=0, rsp_index=0.
REQ-032 Write 0x0000/0xFFFF sixteen times -> entry_count=16; 17th write -> rsp_err=1, tcam_write_enable never asserted, count stays 16; search any key -> rsp_hit=1, rsp_index=0, rsp_multi=1.
REQ-033 Hold rsp_ready=0 for 5 cycles after a search -> rsp_valid and rsp_* stable, cmd_ready=0; release -> one IDLE cycle then next accept.
REQ-034 Clear after 3 writes -> tcam_reset pulse one cycle, entry_count=0; search -> rsp_hit=0.
REQ-035 Assert reset during WCHK -> outputs at reset values immediately, entry_count=0, no rsp_valid; op 11 after reset -> rsp_err=1 after 1 cycle.

Source files
------------

// File: rtl/tcam_ctrl_if.sv
// Command/response handshake bundle between a requester and the TCAM controller.
interface tcam_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [3:0]  rsp_index;
  logic        rsp_multi;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_multi, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_multi, rsp_err
  );
endinterface

// File: rtl/tcam_ctrl.sv
// Sequences write/search/clear commands onto a 16-entry TCAM and returns one
// response per command; tracks how many entries have been written since clear.
module tcam_ctrl (
  input  logic          clk,
  input  logic          reset,
  tcam_ctrl_if.slave    bus,
  output logic [4:0]    entry_count,
  output logic          tcam_reset,
  output logic          tcam_write_enable,
  output logic [15:0]   tcam_data,
  output logic [15:0]   tcam_mask,
  input  logic [15:0]   tcam_hits,
  input  logic          tcam_write_success
);

  typedef enum logic [2:0] {IDLE, WRITE, WCHK, SEARCH, SCAP, CLEAR, RESP} state_t;
  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SEARCH = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  localparam logic [4:0] FULL = 5'd16;

  state_t      state_q, state_d;
  logic        init_done_q;
  logic [4:0]  count_q, count_d;
  logic [15:0] data_q, mask_q;
  logic        hit_q, multi_q, err_q;
  logic [3:0]  index_q;
  logic        load_rsp;
  logic        hit_d, multi_d, err_d;
  logic [3:0]  index_d;
  logic        accept;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest_set = 4'(i);
  endfunction

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_rsp = 1'b0;
    hit_d    = 1'b0;
    index_d  = 4'd0;
    multi_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op_t'(bus.cmd_op))
            OP_WRITE: begin
              if (count_q == FULL) begin
                state_d  = RESP;
                load_rsp = 1'b1;
                err_d    = 1'b1;
              end else begin
                state_d = WRITE;
              end
            end
            OP_SEARCH: state_d = SEARCH;
            OP_CLEAR:  state_d = CLEAR;
            OP_RSVD: begin
              state_d  = RESP;
              load_rsp = 1'b1;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      WRITE:  state_d = WCHK;
      WCHK: begin
        state_d  = RESP;
        load_rsp = 1'b1;
        if (tcam_write_success) begin
          count_d = count_q + 5'd1;
          index_d = count_q[3:0];
        end else begin
          err_d = 1'b1;
        end
      end
      SEARCH: state_d = SCAP;
      SCAP: begin
        state_d  = RESP;
        load_rsp = 1'b1;
        hit_d    = |tcam_hits;
        index_d  = lowest_set(tcam_hits);
        multi_d  = (tcam_hits & (tcam_hits - 16'd1)) != 16'd0;
      end
      CLEAR: begin
        state_d  = RESP;
        load_rsp = 1'b1;
        count_d  = 5'd0;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      init_done_q <= 1'b0;
      count_q     <= 5'd0;
      data_q      <= 16'd0;
      mask_q      <= 16'd0;
      hit_q       <= 1'b0;
      index_q     <= 4'd0;
      multi_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= 1'b1;
      count_q     <= count_d;
      if (accept) begin
        data_q <= bus.cmd_data;
        mask_q <= bus.cmd_mask;
      end
      if (load_rsp) begin
        hit_q   <= hit_d;
        index_q <= index_d;
        multi_q <= multi_d;
        err_q   <= err_d;
      end
    end
  end

  // The TCAM is held in clear until the first clock edge after reset releases.
  assign tcam_reset        = !init_done_q || (state_q == CLEAR);
  assign tcam_write_enable = (state_q == WRITE);
  assign tcam_data         = data_q;
  assign tcam_mask         = mask_q;
  assign entry_count       = count_q;

  assign bus.cmd_ready = init_done_q && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_hit   = hit_q;
  assign bus.rsp_index = index_q;
  assign bus.rsp_multi = multi_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed scoreboard bench for tcam_ctrl: the driver queues hand-computed
// responses, a monitor pops and compares them as the controller presents them.
module tb_tcam_ctrl;

  typedef struct packed {
    logic       hit;
    logic [3:0] index;
    logic       multi;
    logic       err;
    logic [4:0] count;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  entry_count;
  logic        tcam_reset, tcam_write_enable;
  logic [15:0] tcam_data, tcam_mask, tcam_hits;
  logic        tcam_write_success;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   we_cnt   = 0;
  int   clr_cnt  = 0;
  bit   seen     = 1'b0;
  bit   fail_write = 1'b0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  tcam_ctrl_if bus ();

  tcam_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .entry_count        (entry_count),
    .tcam_reset         (tcam_reset),
    .tcam_write_enable  (tcam_write_enable),
    .tcam_data          (tcam_data),
    .tcam_mask          (tcam_mask),
    .tcam_hits          (tcam_hits),
    .tcam_write_success (tcam_write_success)
  );

  // Behavioural TCAM: stored data/mask pairs, match ignores entry and key masks.
  logic [15:0] ent_data [16];
  logic [15:0] ent_mask [16];
  logic [15:0] ent_valid;
  int          ent_n;

  always @(posedge clk) begin
    if (tcam_reset) begin
      ent_valid <= '0;
      ent_n     <= 0;
    end else if (tcam_write_enable && !fail_write && ent_n < 16) begin
      ent_data[ent_n]  <= tcam_data;
      ent_mask[ent_n]  <= tcam_mask;
      ent_valid[ent_n] <= 1'b1;
      ent_n            <= ent_n + 1;
    end
  end

  always_comb begin
    tcam_hits = '0;
    for (int i = 0; i < 16; i++)
      tcam_hits[i] = ent_valid[i] &&
                     (((tcam_data ^ ent_data[i]) & ~(ent_mask[i] | tcam_mask)) == 16'd0);
  end

  assign tcam_write_success = !fail_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic hit, input logic [3:0] idx, input logic multi,
                              input logic err, input logic [4:0] cnt);
    mk = '{hit: hit, index: idx, multi: multi, err: err, count: cnt};
  endfunction

  // Monitor: one comparison set per response, plus pulse bookkeeping.
  always @(negedge clk) begin
    rsp_t e;
    if (tcam_write_enable) we_cnt++;
    if (tcam_reset && reset) clr_cnt++;
    if (reset) check("we_rst_excl", 32'(tcam_write_enable & tcam_reset), 0);
    if (!bus.rsp_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_hit",     32'(bus.rsp_hit),   32'(e.hit));
        check("rsp_index",   32'(bus.rsp_index), 32'(e.index));
        check("rsp_multi",   32'(bus.rsp_multi), 32'(e.multi));
        check("rsp_err",     32'(bus.rsp_err),   32'(e.err));
        check("entry_count", 32'(entry_count),   32'(e.count));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    if (!ok) check("cmd_ready_timeout", 0, 1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input logic [15:0] mask,
                        input rsp_t exp, input int exp_lat, input int exp_we,
                        input int exp_clr, input int hold);
    int       we0, clr0, lat;
    bit       ok;
    logic [6:0] snap;
    wait_ready(ok);
    if (!ok) return;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_mask  = mask;
    bus.rsp_ready = (hold == 0);
    we0  = we_cnt;
    clr0 = clr_cnt;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      check("rsp_timeout", 0, 1);
      bus.rsp_ready = 1'b1;
      return;
    end
    check("latency", lat, exp_lat);
    if (hold > 0) begin
      snap = {bus.rsp_hit, bus.rsp_index, bus.rsp_multi, bus.rsp_err};
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.rsp_valid), 1);
        check("hold_stable", 32'({bus.rsp_hit, bus.rsp_index, bus.rsp_multi, bus.rsp_err}),
              32'(snap));
        check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid_drop", 32'(bus.rsp_valid), 0);
    check("idle_ready", 32'(bus.cmd_ready), 1);
    check("we_pulses", we_cnt - we0, exp_we);
    check("clr_pulses", clr_cnt - clr0, exp_clr);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready",  32'(bus.cmd_ready), 0);
    check("rst_rsp_valid",  32'(bus.rsp_valid), 0);
    check("rst_rsp_fields", 32'({bus.rsp_hit, bus.rsp_index, bus.rsp_multi, bus.rsp_err}), 0);
    check("rst_count",      32'(entry_count), 0);
    check("rst_tcam_reset", 32'(tcam_reset), 1);
    check("rst_we",         32'(tcam_write_enable), 0);
    check("rst_data_mask",  32'({tcam_data, tcam_mask}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
    $fatal(1);
  end

  initial begin
    bit ok;
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 16'd0;
    bus.cmd_mask  = 16'd0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_tcam_reset", 32'(tcam_reset), 0);
    check("post_rst_cmd_ready",  32'(bus.cmd_ready), 1);

    // Masked entry matches a key differing only in ignored bits.
    do_cmd(2'b00, 16'h0060, 16'h000F, mk(0, 0, 0, 0, 1), 3, 1, 0, 0);
    do_cmd(2'b01, 16'h006A, 16'h0000, mk(1, 0, 0, 0, 1), 3, 0, 0, 0);

    // Entry 0 misses 0x00E9, so entry 1 is the lowest hit.
    do_cmd(2'b10, 16'h0000, 16'h0000, mk(0, 0, 0, 0, 0), 2, 0, 1, 0);
    do_cmd(2'b00, 16'h007E, 16'h0052, mk(0, 0, 0, 0, 1), 3, 1, 0, 0);
    do_cmd(2'b00, 16'h00E9, 16'h0000, mk(0, 1, 0, 0, 2), 3, 1, 0, 0);
    do_cmd(2'b01, 16'h00E9, 16'h0000, mk(1, 1, 0, 0, 2), 3, 0, 0, 0);
    do_cmd(2'b01, 16'h1234, 16'h0000, mk(0, 0, 0, 0, 2), 3, 0, 0, 0);

    // TCAM rejects a write: error, count unchanged.
    fail_write = 1'b1;
    do_cmd(2'b00, 16'h5555, 16'h0000, mk(0, 0, 0, 1, 2), 3, 1, 0, 0);
    fail_write = 1'b0;

    // Third write, then clear wipes everything.
    do_cmd(2'b00, 16'h1234, 16'h0000, mk(0, 2, 0, 0, 3), 3, 1, 0, 0);
    do_cmd(2'b10, 16'h0000, 16'h0000, mk(0, 0, 0, 0, 0), 2, 0, 1, 0);
    do_cmd(2'b01, 16'h1234, 16'h0000, mk(0, 0, 0, 0, 0), 3, 0, 0, 0);

    // Fill all sixteen slots, then overflow.
    for (int i = 0; i < 16; i++)
      do_cmd(2'b00, 16'h0000, 16'hFFFF, mk(0, 4'(i), 0, 0, 5'(i + 1)), 3, 1, 0, 0);
    do_cmd(2'b00, 16'h0000, 16'hFFFF, mk(0, 0, 0, 1, 16), 1, 0, 0, 0);
    do_cmd(2'b01, 16'hBEEF, 16'h0000, mk(1, 0, 1, 0, 16), 3, 0, 0, 0);

    // Response back-pressure for five cycles.
    do_cmd(2'b01, 16'h0F0F, 16'h0000, mk(1, 0, 1, 0, 16), 3, 0, 0, 5);

    // Reset during WCHK aborts the write with no response.
    do_cmd(2'b10, 16'h0000, 16'h0000, mk(0, 0, 0, 0, 0), 2, 0, 1, 0);
    do_cmd(2'b00, 16'h0AAA, 16'h0000, mk(0, 0, 0, 0, 1), 3, 1, 0, 0);
    wait_ready(ok);
    if (ok) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 16'h0BBB;
      bus.cmd_mask  = 16'h00F0;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs();
      repeat (3) begin
        @(negedge clk);
        check("abort_no_rsp", 32'(bus.rsp_valid), 0);
      end
      #2 reset = 1'b1;
      @(posedge clk);
      #1 check("abort_ready", 32'(bus.cmd_ready), 1);
    end

    // Reserved op answers with an error one cycle after acceptance.
    do_cmd(2'b11, 16'hFFFF, 16'h0000, mk(0, 0, 0, 1, 0), 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
